// File: rtl/mmio_fifo_pkg.sv
// Shared constants and types for the MMIO-attached FIFO: register map, status layout, defaults.
// The optional high-water register is enabled by defining MMIO_FIFO_HIGH_WATER_EN.
package mmio_fifo_pkg;

   localparam int MMIO_FIFO_WIDTH = 64;
   localparam int MMIO_FIFO_DEPTH = 8;

   localparam logic [15:0] MMIO_FIFO_DATA_ADDR   = 16'h0020;
   localparam logic [15:0] MMIO_FIFO_STATUS_ADDR = 16'h0022;
   localparam logic [15:0] MMIO_FIFO_HWM_ADDR    = 16'h0024;

   localparam int STATUS_EMPTY_BIT     = 56;
   localparam int STATUS_FULL_BIT      = 57;
   localparam int STATUS_OVERFLOW_BIT  = 58;
   localparam int STATUS_UNDERFLOW_BIT = 59;

   // Status register image; count is zero-extended into the low field.
   typedef struct packed {
      logic [3:0]  rsvd;
      logic        underflow;
      logic        overflow;
      logic        full;
      logic        empty;
      logic [55:0] count;
   } mmio_fifo_status_t;

   // Encoded as {push accepted, pop accepted}.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic mmio_fifo_status_t pack_status(
      input logic [55:0] cnt,
      input logic        is_empty,
      input logic        is_full,
      input logic        ovf,
      input logic        unf
   );
      mmio_fifo_status_t s;
      s           = '0;
      s.count     = cnt;
      s.empty     = is_empty;
      s.full      = is_full;
      s.overflow  = ovf;
      s.underflow = unf;
      return s;
   endfunction

endpackage

// File: rtl/mmio_fifo_mem.sv
// Register-array storage for the MMIO FIFO: one synchronous write port and an
// asynchronous read port so the head word can fall through without a cycle of latency.
module mmio_fifo_mem
   import mmio_fifo_pkg::*;
#(
   parameter int WIDTH = MMIO_FIFO_WIDTH,
   parameter int DEPTH = MMIO_FIFO_DEPTH,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_reg [DEPTH];

   // Contents are deliberately not reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_reg[waddr] <= wdata;
      end
   end

   assign rdata = mem_reg[raddr];

endmodule

// File: rtl/mmio_fifo.sv
// Full/empty-aware FIFO fed by MMIO data-register writes and drained by data-register reads.
// Defining MMIO_FIFO_HIGH_WATER_EN adds a high_water output tracking peak occupancy.
module mmio_fifo
   import mmio_fifo_pkg::*;
#(
   parameter int WIDTH = MMIO_FIFO_WIDTH,
   parameter int DEPTH = MMIO_FIFO_DEPTH,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow
`ifdef MMIO_FIFO_HIGH_WATER_EN
   ,
   output logic [CW-1:0]    high_water
`endif
);

   localparam int AW = CW - 1;

   logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]    count_reg, count_next;
   logic             overflow_reg, overflow_next;
   logic             underflow_reg, underflow_next;
   logic             push_ok, pop_ok, mem_we;
   logic [WIDTH-1:0] mem_rdata;
   fifo_op_e         op;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == CW'(DEPTH));

   // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
   assign push_ok = wr_en && (!full || rd_en);
   assign pop_ok  = rd_en && !empty;
   assign op      = fifo_op_e'({push_ok, pop_ok});
   assign mem_we  = push_ok && !rst && !clr;

   always_comb begin
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      count_next     = count_reg;
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;

      unique case (op)
         OP_PUSH: count_next = count_reg + CW'(1);
         OP_POP:  count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase

      if (push_ok) begin
         wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      if (wr_en && !push_ok) begin
         overflow_next = 1'b1;
      end
      if (rd_en && empty) begin
         underflow_next = 1'b1;
      end

      if (clr) begin
         wr_ptr_next    = '0;
         rd_ptr_next    = '0;
         count_next     = '0;
         overflow_next  = 1'b0;
         underflow_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         count_reg     <= count_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

`ifdef MMIO_FIFO_HIGH_WATER_EN
   logic [CW-1:0] high_water_reg, high_water_next;

   // Follows the registered count, so a new peak shows up one cycle later.
   always_comb begin
      high_water_next = high_water_reg;
      if (count_reg > high_water_reg) begin
         high_water_next = count_reg;
      end
      if (clr) begin
         high_water_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         high_water_reg <= '0;
      end else begin
         high_water_reg <= high_water_next;
      end
   end

   assign high_water = high_water_reg;
`endif

   mmio_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr_reg),
      .wdata (wr_data),
      .raddr (rd_ptr_reg),
      .rdata (mem_rdata)
   );

   assign rd_data   = empty ? '0 : mem_rdata;
   assign count     = count_reg;
   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;

endmodule

// File: tb/tb_mmio_fifo.sv
// Self-checking bench for mmio_fifo (DEPTH=8, WIDTH=64): table-driven vectors plus a data scoreboard.
// Also checks high_water when MMIO_FIFO_HIGH_WATER_EN is defined.
module tb_mmio_fifo;

   localparam int W  = 64;
   localparam int D  = 8;
   localparam int CW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr = 1'b0;
   logic          wr_en = 1'b0;
   logic [W-1:0]  wr_data = '0;
   logic          rd_en = 1'b0;
   logic [W-1:0]  rd_data;
   logic          empty, full, overflow, underflow;
   logic [CW-1:0] count;
`ifdef MMIO_FIFO_HIGH_WATER_EN
   logic [CW-1:0] high_water;
`endif

   mmio_fifo #(.WIDTH(W), .DEPTH(D)) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .empty      (empty),
      .full       (full),
      .count      (count),
      .overflow   (overflow),
      .underflow  (underflow)
`ifdef MMIO_FIFO_HIGH_WATER_EN
      ,
      .high_water (high_water)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          rs, c, w, r;
      logic [63:0] data;
      int          cnt;
      logic [63:0] rdx;
      bit          ovf, unf;
   } vec_t;

   vec_t        vecs[$];
   logic [63:0] sb[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   function automatic vec_t mk(string nm, bit rs, bit c, bit w, bit r, logic [63:0] d,
                               int cnt, logic [63:0] rdx, bit ov, bit un);
      vec_t v;
      v.name = nm; v.rs = rs; v.c = c; v.w = w; v.r = r; v.data = d;
      v.cnt = cnt; v.rdx = rdx; v.ovf = ov; v.unf = un;
      return v;
   endfunction

   function automatic void add(string nm, bit rs, bit c, bit w, bit r, logic [63:0] d,
                               int cnt, logic [63:0] rdx, bit ov, bit un);
      vecs.push_back(mk(nm, rs, c, w, r, d, cnt, rdx, ov, un));
   endfunction

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   // One clock of stimulus; scoreboard compares the head word before a pop lands.
   task automatic apply(vec_t v);
      bit do_push, do_pop;
      @(negedge clk);
      rst = v.rs; clr = v.c; wr_en = v.w; rd_en = v.r; wr_data = v.data;
      if (v.rs || v.c) begin
         sb.delete();
      end else begin
         if (v.r && sb.size() > 0) check({v.name, ".sb_head"}, rd_data, sb[0]);
         do_pop  = v.r && sb.size() > 0;
         do_push = v.w && (sb.size() < D || v.r);
         if (do_pop)  void'(sb.pop_front());
         if (do_push) sb.push_back(v.data);
      end
      @(posedge clk);
      #1;
      check({v.name, ".count"},     64'(count),     64'(v.cnt));
      check({v.name, ".empty"},     64'(empty),     64'(v.cnt == 0));
      check({v.name, ".full"},      64'(full),      64'(v.cnt == D));
      check({v.name, ".overflow"},  64'(overflow),  64'(v.ovf));
      check({v.name, ".underflow"}, 64'(underflow), 64'(v.unf));
      check({v.name, ".rd_data"},   rd_data,        v.rdx);
      $display("txn %-18s rst=%0b clr=%0b wr=%0b rd=%0b din=%0h -> count=%0d rd_data=%0h ovf=%0b unf=%0b",
               v.name, v.rs, v.c, v.w, v.r, v.data, count, rd_data, overflow, underflow);
      rst = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state, with a push request held during reset that must be discarded.
      wr_en = 1'b1; wr_data = 64'hDEAD;
      repeat (2) @(posedge clk);
      #1;
      check("reset.count",     64'(count),     64'd0);
      check("reset.empty",     64'(empty),     64'd1);
      check("reset.full",      64'(full),      64'd0);
      check("reset.rd_data",   rd_data,        64'd0);
      check("reset.overflow",  64'(overflow),  64'd0);
      check("reset.underflow", 64'(underflow), 64'd0);
`ifdef MMIO_FIFO_HIGH_WATER_EN
      check("reset.high_water", 64'(high_water), 64'd0);
`endif
      rst = 1'b0; wr_en = 1'b0;

      // Basic push/pop with fall-through.
      add("t1_push11", 0, 0, 1, 0, 64'h11, 1, 64'h11, 0, 0);
      add("t1_push22", 0, 0, 1, 0, 64'h22, 2, 64'h11, 0, 0);
      add("t1_push33", 0, 0, 1, 0, 64'h33, 3, 64'h11, 0, 0);
      add("t1_pop1",   0, 0, 0, 1, 64'h0,  2, 64'h22, 0, 0);
      add("t1_pop2",   0, 0, 0, 1, 64'h0,  1, 64'h33, 0, 0);
      add("t1_pop3",   0, 0, 0, 1, 64'h0,  0, 64'h0,  0, 0);
      // Fill, overflow, drain, clear.
      for (int k = 1; k <= 8; k++) add("t2_fill", 0, 0, 1, 0, 64'(k), k, 64'h1, 0, 0);
      add("t2_push99", 0, 0, 1, 0, 64'h99, 8, 64'h1, 1, 0);
      for (int k = 1; k <= 8; k++)
         add("t2_drain", 0, 0, 0, 1, 64'h0, 8 - k, (k < 8) ? 64'(k + 1) : 64'h0, 1, 0);
      add("t2_clr", 0, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0);
      // Simultaneous push+pop while full.
      for (int k = 1; k <= 8; k++) add("t3_fill", 0, 0, 1, 0, 64'(k), k, 64'h1, 0, 0);
      add("t3_both_full", 0, 0, 1, 1, 64'hAA, 8, 64'h2, 0, 0);
      for (int k = 1; k <= 8; k++)
         add("t3_drain", 0, 0, 0, 1, 64'h0, 8 - k,
             (k < 7) ? 64'(k + 2) : ((k == 7) ? 64'hAA : 64'h0), 0, 0);
      // Pop on empty alongside a push.
      add("t4_wr_rd_empty", 0, 0, 1, 1, 64'h55, 1, 64'h55, 0, 1);
      add("t4_pop",         0, 0, 0, 1, 64'h0,  0, 64'h0,  0, 1);
      add("t4_clr",         0, 1, 0, 0, 64'h0,  0, 64'h0,  0, 0);
      // Wrap-around at a steady depth of 3.
      for (int k = 0; k < 3; k++) add("t5_prefill", 0, 0, 1, 0, 64'(100 + k), k + 1, 64'd100, 0, 0);
      for (int k = 0; k < 20; k++) add("t5_pair", 0, 0, 1, 1, 64'(103 + k), 3, 64'(101 + k), 0, 0);
      for (int k = 0; k < 3; k++)
         add("t5_drain", 0, 0, 0, 1, 64'h0, 2 - k, (k < 2) ? 64'(121 + k) : 64'h0, 0, 0);

      foreach (vecs[i]) apply(vecs[i]);

      // Reset mid-fill with requests in flight, then pointers restart cleanly.
      for (int k = 1; k <= 5; k++) apply(mk("t6_fill", 0, 0, 1, 0, 64'(16 * k), k, 64'h10, 0, 0));
      apply(mk("t6_rst",    1, 0, 1, 1, 64'hEE, 0, 64'h0,  0, 0));
      apply(mk("t6_push77", 0, 0, 1, 0, 64'h77, 1, 64'h77, 0, 0));
      apply(mk("t6_pop77",  0, 0, 0, 1, 64'h0,  0, 64'h0,  0, 0));

      // Clear mid-fill; high_water must peak at 5 and then drop to 0.
      for (int k = 1; k <= 5; k++) apply(mk("t7_fill", 0, 0, 1, 0, 64'(k), k, 64'h1, 0, 0));
      apply(mk("t7_idle", 0, 0, 0, 0, 64'h0, 5, 64'h1, 0, 0));
`ifdef MMIO_FIFO_HIGH_WATER_EN
      check("t7.high_water_before", 64'(high_water), 64'd5);
`endif
      apply(mk("t7_clr", 0, 1, 1, 1, 64'hEE, 0, 64'h0, 0, 0));
`ifdef MMIO_FIFO_HIGH_WATER_EN
      check("t7.high_water_after", 64'(high_water), 64'd0);
`endif

      // Clear with count=5 and overflow set.
      for (int k = 1; k <= 8; k++) apply(mk("t8_fill", 0, 0, 1, 0, 64'(k), k, 64'h1, 0, 0));
      apply(mk("t8_ovf", 0, 0, 1, 0, 64'h99, 8, 64'h1, 1, 0));
      for (int k = 1; k <= 3; k++) apply(mk("t8_pop", 0, 0, 0, 1, 64'h0, 8 - k, 64'(k + 1), 1, 0));
      apply(mk("t8_clr",   0, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0));
      apply(mk("t8_after", 0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
